jt10_adpcm_divn: RTL and testbench

- Parametrised iterative divider computing d = a/b and r = a - b*d for the ADPCM decoders; successor of the single-mode 1-bit/step divider.
- Adds:
  - signed and unsigned modes, selectable per operation (truncating, C semantics);
  - configurable bits retired per step;
  - divide-by-zero and overflow flags;
  - a done strobe.
- Sits between the ADPCM register bank / step logic and the accumulator. All work gated by the shared clock enable.

---
 rtl/jt10_adpcm_div_pkg.sv | 22 ++
 rtl/jt10_adpcm_div_step.sv | 26 ++
 rtl/jt10_adpcm_divn.sv | 176 +++++++++++++++++
 tb/tb_jt10_adpcm_divn.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt10_adpcm_div_pkg.sv
// rtl/jt10_adpcm_div_pkg.sv - shared types and helpers for the ADPCM divider
// Purpose : FSM state encoding, step counter sizing and the most-negative
//           constant used by jt10_adpcm_divn and jt10_adpcm_div_step.
// Ports   : none (package).
package jt10_adpcm_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

  // Width of the step counter: must hold DW/BPC.
  function automatic int cnt_width(input int dw, input int bpc);
    return $clog2(dw / bpc + 1);
  endfunction

  // Most-negative two's-complement value, left aligned; shift right by
  // (64-DW) to get the DW-bit constant.
  localparam logic [63:0] MOST_NEG_64 = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/jt10_adpcm_div_step.sv
// rtl/jt10_adpcm_div_step.sv - one combinational restoring division step
// Purpose : shift one dividend bit into the partial remainder and subtract
//           the divisor magnitude when it fits.
// Ports   : rem_in  partial remainder in      dbit    next dividend MSB
//           div     divisor magnitude         rem_out partial remainder out
//           qbit    quotient bit retired by this step
module jt10_adpcm_div_step #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] rem_in,
  input  logic          dbit,
  input  logic [DW-1:0] div,
  output logic [DW-1:0] rem_out,
  output logic          qbit
);

  logic [DW:0]   shifted;
  logic [DW-1:0] diff_lo;

  assign shifted = {rem_in, dbit};
  assign qbit    = (shifted >= {1'b0, div});
  // The difference is below |b| whenever it is kept, so DW bits suffice.
  assign diff_lo = DW'(shifted - {1'b0, div});
  assign rem_out = qbit ? diff_lo : shifted[DW-1:0];

endmodule

// File: rtl/jt10_adpcm_divn.sv
// rtl/jt10_adpcm_divn.sv - iterative signed/unsigned divider, BPC bits per cen
// Purpose : d = a/b, r = a - b*d with truncating (C) semantics; divide by zero
//           and signed overflow flagged. Define JT10_ADPCM_DIV_ROUND_EN to
//           round the quotient to nearest (ties away from zero) instead.
// Ports   : clk, rst (async, active-high), cen (clock enable)
//           start/sgn/a/b  operation request, sampled with cen
//           d/r            quotient/remainder, held until the next FIX
//           busy/done      in-progress flag and one-cen-period result strobe
//           div0/ovf       exception flags of the last operation
module jt10_adpcm_divn
  import jt10_adpcm_div_pkg::*;
#(
  parameter int DW  = 16,
  parameter int BPC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          start,
  input  logic          sgn,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] d,
  output logic [DW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          div0,
  output logic          ovf
);

  localparam int            STEPS    = DW / BPC;
  localparam int            CW       = cnt_width(DW, BPC);
  localparam logic [DW-1:0] MOST_NEG = DW'(MOST_NEG_64 >> (64 - DW));

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvd_q;     // dividend magnitude, quotient shifts in at LSB
  logic [DW-1:0] div_q;     // divisor magnitude
  logic [DW-1:0] rem_q;     // partial remainder
  logic [DW-1:0] a_q;       // raw dividend for the b==0 result
  logic          sa_q, sb_q, sgn_q, ovf_case_q;

  // ---------------- operand conditioning at start ----------------
  logic [DW-1:0] a_mag, b_mag;
  logic          a_neg, b_neg, ovf_case;

  assign a_neg    = sgn & a[DW-1];
  assign b_neg    = sgn & b[DW-1];
  // -MOST_NEG wraps back to 2^(DW-1), which is the exact magnitude unsigned.
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign ovf_case = sgn & (a == MOST_NEG) & (b == '1);

  // ---------------- restoring step chain ----------------
  logic [BPC:0][DW-1:0] rem_c;
  logic [BPC-1:0]       qbits;
  logic [DW-1:0]        dvd_next;

  assign rem_c[0] = rem_q;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    jt10_adpcm_div_step #(.DW(DW)) u_step (
      .rem_in  (rem_c[i]),
      .dbit    (dvd_q[DW-1-i]),
      .div     (div_q),
      .rem_out (rem_c[i+1]),
      .qbit    (qbits[BPC-1-i])
    );
  end

  assign dvd_next = DW'({dvd_q, qbits});

  // ---------------- result correction ----------------
  logic [DW-1:0] q_mag, rem_mag, fix_d, fix_r;
  logic          neg_d, neg_r;

  always_comb begin
    q_mag   = dvd_q;
    rem_mag = rem_q;
`ifdef JT10_ADPCM_DIV_ROUND_EN
    // Round magnitude up when the remainder is at least half the divisor;
    // the remainder then becomes rem-|b| so that r = a - b*d still holds.
    if ({rem_q, 1'b0} >= {1'b0, div_q}) begin
      q_mag   = dvd_q + 1'b1;
      rem_mag = rem_q - div_q;
    end
`endif
    neg_d = sgn_q & (sa_q ^ sb_q);
    neg_r = sgn_q & sa_q;
    fix_d = neg_d ? -q_mag : q_mag;
    fix_r = neg_r ? -rem_mag : rem_mag;
    if (div_q == '0) begin
      fix_d = '1;
      fix_r = a_q;
    end else if (ovf_case_q) begin
      fix_d = MOST_NEG;
      fix_r = '0;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    if (cen) begin
      if (start) begin
        state_d = ST_RUN;
      end else begin
        case (state_q)
          ST_RUN:  if (cnt_q == '0) state_d = ST_FIX;
          ST_FIX:  state_d = ST_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      dvd_q      <= '0;
      div_q      <= '0;
      rem_q      <= '0;
      a_q        <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      sgn_q      <= 1'b0;
      ovf_case_q <= 1'b0;
      d          <= '0;
      r          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div0       <= 1'b0;
      ovf        <= 1'b0;
    end else if (cen) begin
      done <= 1'b0;
      if (start) begin
        dvd_q      <= a_mag;
        div_q      <= b_mag;
        rem_q      <= '0;
        a_q        <= a;
        sa_q       <= a_neg;
        sb_q       <= b_neg;
        sgn_q      <= sgn;
        ovf_case_q <= ovf_case;
        cnt_q      <= CW'(STEPS - 1);
        busy       <= 1'b1;
        div0       <= 1'b0;
        ovf        <= 1'b0;
      end else begin
        case (state_q)
          ST_RUN: begin
            dvd_q <= dvd_next;
            rem_q <= rem_c[BPC];
            cnt_q <= cnt_q - 1'b1;
          end
          ST_FIX: begin
            d    <= fix_d;
            r    <= fix_r;
            div0 <= (div_q == '0);
            ovf  <= ovf_case_q & (div_q != '0);
            done <= 1'b1;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcm_divn.sv
// tb/tb_jt10_adpcm_divn.sv - self-checking bench for jt10_adpcm_divn (BPC=1 and BPC=4)
module tb_jt10_adpcm_divn;

  logic        clk = 1'b0;
  logic        rst, cen, start, sgn;
  logic [15:0] a, b;
  logic [15:0] o_d [2];
  logic [15:0] o_r [2];
  logic        o_busy [2];
  logic        o_done [2];
  logic        o_div0 [2];
  logic        o_ovf  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cen_mode = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  jt10_adpcm_divn #(.DW(16), .BPC(1)) u_div1 (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .sgn(sgn), .a(a), .b(b),
    .d(o_d[0]), .r(o_r[0]), .busy(o_busy[0]), .done(o_done[0]),
    .div0(o_div0[0]), .ovf(o_ovf[0])
  );

  jt10_adpcm_divn #(.DW(16), .BPC(4)) u_div4 (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .sgn(sgn), .a(a), .b(b),
    .d(o_d[1]), .r(o_r[1]), .busy(o_busy[1]), .done(o_done[1]),
    .div0(o_div0[1]), .ovf(o_ovf[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference division from plain integer arithmetic.
  function automatic void ref_div(input logic [15:0] av, input logic [15:0] bv, input logic s,
                                  output logic [15:0] rd, output logic [15:0] rr,
                                  output logic rdz, output logic rov);
    longint x, y, q, rm;
    rdz = 0; rov = 0;
    if (bv == 16'h0) begin
      rd = 16'hFFFF; rr = av; rdz = 1;
    end else if (s && av == 16'h8000 && bv == 16'hFFFF) begin
      rd = 16'h8000; rr = 16'h0; rov = 1;
    end else begin
      x = s ? longint'($signed(av)) : longint'(av);
      y = s ? longint'($signed(bv)) : longint'(bv);
      q = x / y;
      rm = x - y * q;
`ifdef JT10_ADPCM_DIV_ROUND_EN
      if (2 * (rm < 0 ? -rm : rm) >= (y < 0 ? -y : y))
        q = q + (((x < 0) != (y < 0)) ? -1 : 1);
      rm = x - y * q;
`endif
      rd = q[15:0];
      rr = rm[15:0];
    end
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 17 : 5;
  endfunction

  // Cycle-level model: counts enabled edges after a start.
  int          m_left [2];
  bit          m_busy [2], m_done [2], m_div0 [2], m_ovf [2];
  logic [15:0] m_d [2], m_r [2], p_d [2], p_r [2];
  logic        p_dz [2], p_ov [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_left[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_div0[k] = 0; m_ovf[k] = 0;
        m_d[k] = 0; m_r[k] = 0;
      end else if (cen) begin
        m_done[k] = 0;
        if (start) begin
          ref_div(a, b, sgn, p_d[k], p_r[k], p_dz[k], p_ov[k]);
          m_left[k] = lat(k); m_busy[k] = 1; m_div0[k] = 0; m_ovf[k] = 0;
        end else if (m_busy[k]) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_busy[k] = 0; m_done[k] = 1;
            m_d[k] = p_d[k]; m_r[k] = p_r[k]; m_div0[k] = p_dz[k]; m_ovf[k] = p_ov[k];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d.busy", k), o_busy[k], m_busy[k]);
        check($sformatf("u%0d.done", k), o_done[k], m_done[k]);
        check($sformatf("u%0d.d", k), o_d[k], m_d[k]);
        check($sformatf("u%0d.r", k), o_r[k], m_r[k]);
        check($sformatf("u%0d.div0", k), o_div0[k], m_div0[k]);
        check($sformatf("u%0d.ovf", k), o_ovf[k], m_ovf[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = (cyc % 3 == 0);
      default: cen = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic issue_start(input logic [15:0] av, input logic [15:0] bv, input logic s);
    for (int i = 0; i < 8 && !cen; i++) tick();
    cen = 1'b1;
    a = av; b = bv; sgn = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic count_done(input int k, output int n_en, output bit ok);
    bit acc;
    n_en = 0; ok = 0;
    for (int i = 0; i < 300; i++) begin
      acc = cen;
      tick();
      if (acc) n_en++;
      if (o_done[k]) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!o_busy[0] && !o_busy[1] && !m_busy[0] && !m_busy[1]) break;
      tick();
    end
    check("idle_reached", {o_busy[0], o_busy[1]}, 0);
    tick(); tick();
  endtask

  task automatic run_lit(input string nm, input int k, input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input int elat, input logic [15:0] ed, input logic [15:0] er,
                         input logic edz, input logic eov);
    int n; bit ok;
    issue_start(av, bv, s);
    count_done(k, n, ok);
    check({nm, ".done_seen"}, ok, 1);
    check({nm, ".latency"}, n, elat);
    check({nm, ".d"}, o_d[k], ed);
    check({nm, ".r"}, o_r[k], er);
    check({nm, ".div0"}, o_div0[k], edz);
    check({nm, ".ovf"}, o_ovf[k], eov);
    wait_idle();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] td, tr;
    logic tdz, tov;
    int n, pulses;
    bit acc, prev;
    logic [15:0] seen_d, seen_r;

    rst = 1; cen = 0; start = 0; sgn = 0; a = 0; b = 0;

    // Pin the reference model on hand-worked cases.
    ref_div(16'd1000, 16'd7, 1'b0, td, tr, tdz, tov);
`ifdef JT10_ADPCM_DIV_ROUND_EN
    check("model.1000/7.d", td, 16'd143);
    check("model.1000/7.r", tr, 16'hFFFF);
`else
    check("model.1000/7.d", td, 16'd142);
    check("model.1000/7.r", tr, 16'd6);
`endif
    ref_div(16'h8000, 16'hFFFF, 1'b1, td, tr, tdz, tov);
    check("model.ovf.d", td, 16'h8000);
    check("model.ovf.flag", tov, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    check("reset.d", o_d[0], 0);
    check("reset.r", o_r[0], 0);
    check("reset.busy", o_busy[0], 0);
    check("reset.done", o_done[0], 0);
    rst = 0;
    tick(); tick();

    cen_mode = 0;
`ifdef JT10_ADPCM_DIV_ROUND_EN
    run_lit("u_1000/7",   0, 16'd1000, 16'd7,     0, 17, 16'd143,  16'hFFFF, 0, 0);
    run_lit("s_-1000/7",  0, 16'hFC18, 16'd7,     1, 17, 16'hFF71, 16'h0001, 0, 0);
    run_lit("s_-1000/-7", 0, 16'hFC18, 16'hFFF9,  1, 17, 16'h008F, 16'h0001, 0, 0);
    run_lit("u_8000/FFFF",0, 16'h8000, 16'hFFFF,  0, 17, 16'h0001, 16'h8001, 0, 0);
`else
    run_lit("u_1000/7",   0, 16'd1000, 16'd7,     0, 17, 16'd142,  16'd6,    0, 0);
    run_lit("s_-1000/7",  0, 16'hFC18, 16'd7,     1, 17, 16'hFF72, 16'hFFFA, 0, 0);
    run_lit("s_-1000/-7", 0, 16'hFC18, 16'hFFF9,  1, 17, 16'd142,  16'hFFFA, 0, 0);
    run_lit("u_8000/FFFF",0, 16'h8000, 16'hFFFF,  0, 17, 16'h0000, 16'h8000, 0, 0);
`endif
    run_lit("u_div0",     0, 16'h1234, 16'h0000,  0, 17, 16'hFFFF, 16'h1234, 1, 0);
    run_lit("s_div0",     0, 16'h1234, 16'h0000,  1, 17, 16'hFFFF, 16'h1234, 1, 0);
    run_lit("s_ovf",      0, 16'h8000, 16'hFFFF,  1, 17, 16'h8000, 16'h0000, 0, 1);

    // BPC=4 with a 1-in-3 clock enable.
    cen_mode = 1;
    run_lit("b4_65535/255", 1, 16'd65535, 16'd255, 0, 5, 16'd257, 16'd0, 0, 0);

    // Restart at RUN step 2: only the second operation may report done.
    issue_start(16'd65535, 16'd255, 1'b0);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin acc = cen; tick(); if (acc) n++; end
    issue_start(16'd9, 16'd2, 1'b0);
    pulses = 0; prev = 0; seen_d = 0; seen_r = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (o_done[1] && !prev) begin pulses++; seen_d = o_d[1]; seen_r = o_r[1]; end
      prev = o_done[1];
    end
    check("restart.pulses", pulses, 1);
`ifdef JT10_ADPCM_DIV_ROUND_EN
    check("restart.d", seen_d, 16'd5);
    check("restart.r", seen_r, 16'hFFFF);
`else
    check("restart.d", seen_d, 16'd4);
    check("restart.r", seen_r, 16'd1);
`endif
    wait_idle();

    // Asynchronous reset in the middle of RUN.
    cen_mode = 0;
    issue_start(16'd1000, 16'd7, 1'b0);
    repeat (5) tick();
    rst = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst.u%0d.outs", k),
            {o_d[k], o_r[k], o_busy[k], o_done[k], o_div0[k], o_ovf[k]}, 0);
    end
    tick();
    rst = 0;
    tick();
`ifdef JT10_ADPCM_DIV_ROUND_EN
    run_lit("post_rst_10/4", 0, 16'd10, 16'd4, 0, 17, 16'd3, 16'hFFFE, 0, 0);
`else
    run_lit("post_rst_10/4", 0, 16'd10, 16'd4, 0, 17, 16'd2, 16'd2, 0, 0);
`endif

    // Randomized operations, checked cycle by cycle against the model.
    for (int op = 0; op < 150; op++) begin
      int sel;
      logic [15:0] ra, rb;
      cen_mode = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (sel == 0) rb = 16'h0;
      else if (sel == 1) begin ra = 16'h8000; rb = 16'hFFFF; end
      else if (sel == 2) rb = 16'($urandom_range(1, 15));
      else if (sel == 3) rb = -16'($urandom_range(1, 15));
      issue_start(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 10)) tick();
        issue_start(16'($urandom), 16'($urandom_range(0, 300)), 1'($urandom_range(0, 1)));
      end
      wait_idle();
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
